// File: rtl/apb_master.sv
// APB requester: turns a valid/ready command into one APB transfer
// and returns a valid/ready response with a bounded wait on pready.
module apb_master #(
  parameter int DW      = 32,
  parameter int AW      = 5,
  parameter int TIMEOUT = 16
) (
  input  logic          pclk,
  input  logic          presetn,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [AW-1:0] cmd_addr,
  input  logic          cmd_write,
  input  logic [DW-1:0] cmd_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic [AW-1:0] paddr,
  output logic          psel,
  output logic          penable,
  output logic          pwrite,
  output logic [DW-1:0] pwdata,
  input  logic          pready,
  input  logic [DW-1:0] prdata,
  input  logic          pslverr
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t        r_state;
  state_t        w_state;
  logic          r_cmd_ready;
  logic          w_cmd_ready;
  logic          r_psel;
  logic          w_psel;
  logic          r_penable;
  logic          w_penable;
  logic          r_pwrite;
  logic          w_pwrite;
  logic [AW-1:0] r_paddr;
  logic [AW-1:0] w_paddr;
  logic [DW-1:0] r_pwdata;
  logic [DW-1:0] w_pwdata;
  logic          r_rsp_valid;
  logic          w_rsp_valid;
  logic [DW-1:0] r_rsp_rdata;
  logic [DW-1:0] w_rsp_rdata;
  logic          r_rsp_err;
  logic          w_rsp_err;
  logic [CW-1:0] r_wait;
  logic [CW-1:0] w_wait;

  // Next state and next value of every registered output.
  always_comb begin
    w_state     = r_state;
    w_cmd_ready = r_cmd_ready;
    w_psel      = r_psel;
    w_penable   = r_penable;
    w_pwrite    = r_pwrite;
    w_paddr     = r_paddr;
    w_pwdata    = r_pwdata;
    w_rsp_valid = r_rsp_valid;
    w_rsp_rdata = r_rsp_rdata;
    w_rsp_err   = r_rsp_err;
    w_wait      = r_wait;
    unique case (r_state)
      S_IDLE: begin
        if (cmd_valid && r_cmd_ready) begin
          w_state     = S_SETUP;
          w_cmd_ready = 1'b0;
          w_paddr     = cmd_addr;
          w_pwrite    = cmd_write;
          w_pwdata    = cmd_wdata;
          w_psel      = 1'b1;
          w_penable   = 1'b0;
        end else begin
          w_cmd_ready = 1'b1;
        end
      end
      S_SETUP: begin
        w_state   = S_ACCESS;
        w_penable = 1'b1;
        w_wait    = '0;
      end
      S_ACCESS: begin
        if (pready) begin
          w_state     = S_RESP;
          w_psel      = 1'b0;
          w_penable   = 1'b0;
          w_rsp_valid = 1'b1;
          w_rsp_err   = pslverr;
          w_rsp_rdata = r_pwrite ? '0 : prdata;
        end else if (r_wait == LAST) begin
          w_state     = S_RESP;
          w_psel      = 1'b0;
          w_penable   = 1'b0;
          w_rsp_valid = 1'b1;
          w_rsp_err   = 1'b1;
          w_rsp_rdata = '0;
        end else begin
          w_wait = r_wait + CW'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_state     = S_IDLE;
          w_rsp_valid = 1'b0;
          w_cmd_ready = 1'b1;
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any transfer.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_wait      <= '0;
    end else begin
      r_state     <= w_state;
      r_cmd_ready <= w_cmd_ready;
      r_psel      <= w_psel;
      r_penable   <= w_penable;
      r_pwrite    <= w_pwrite;
      r_paddr     <= w_paddr;
      r_pwdata    <= w_pwdata;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_rdata <= w_rsp_rdata;
      r_rsp_err   <= w_rsp_err;
      r_wait      <= w_wait;
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign psel      = r_psel;
  assign penable   = r_penable;
  assign pwrite    = r_pwrite;
  assign paddr     = r_paddr;
  assign pwdata    = r_pwdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: random commands against a slave model,
// responses checked by a queue-based scoreboard.
module tb_apb_master;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int TO = 16;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    int            lat;
    int            acc;
    int            hold;
  } exp_t;

  logic          pclk = 1'b0;
  logic          presetn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr = '0;
  logic          cmd_write = 1'b0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] paddr;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [DW-1:0] pwdata;
  logic          pready = 1'b0;
  logic [DW-1:0] prdata = '0;
  logic          pslverr = 1'b0;

  apb_master #(.DW(DW), .AW(AW), .TIMEOUT(TO)) dut (
    .pclk      (pclk),
    .presetn   (presetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_write (cmd_write),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .paddr     (paddr),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .pwdata    (pwdata),
    .pready    (pready),
    .prdata    (prdata),
    .pslverr   (pslverr)
  );

  initial forever #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;
  exp_t exp_q[$];

  logic [AW-1:0] a_addr = '0;
  logic          a_wr = 1'b0;
  logic [DW-1:0] a_wdata = '0;
  int            s_wait = 0;
  logic          s_err = 1'b0;
  logic [DW-1:0] s_rdata = '0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Present one command, wait for acceptance, record the expectation.
  task automatic issue(input logic [AW-1:0] ad, input logic wr,
                       input logic [DW-1:0] wd, input int w,
                       input logic e, input logic [DW-1:0] rd,
                       input int hold);
    exp_t x;
    bit ok;
    ok = 1'b0;
    @(negedge pclk);
    cmd_valid = 1'b1;
    cmd_addr  = ad;
    cmd_write = wr;
    cmd_wdata = wd;
    for (int k = 0; k < 400; k++) begin
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge pclk);
    end
    if (!ok) begin
      check("accept_bound", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    a_addr  = ad;
    a_wr    = wr;
    a_wdata = wd;
    s_wait  = w;
    s_err   = e;
    s_rdata = rd;
    x.err   = (w >= TO) ? 1'b1 : e;
    x.rdata = (w >= TO || wr) ? '0 : rd;
    x.lat   = cyc + 1 + 2 + ((w < TO - 1) ? w : TO - 1);
    x.acc   = (w < TO) ? w + 1 : TO;
    x.hold  = hold;
    exp_q.push_back(x);
    @(posedge pclk);
    #1;
    cmd_valid = 1'b0;
    cmd_addr  = AW'($urandom);
    cmd_write = 1'($urandom);
    cmd_wdata = $urandom;
  endtask

  // Slave model: pready after s_wait ACCESS cycles, noise elsewhere.
  initial begin
    int acc_n;
    acc_n = 0;
    forever begin
      @(negedge pclk);
      if (psel && penable) begin
        if (acc_n == s_wait) begin
          pready  = 1'b1;
          prdata  = s_rdata;
          pslverr = s_err;
        end else begin
          pready  = 1'b0;
          prdata  = $urandom;
          pslverr = 1'($urandom);
        end
        acc_n++;
      end else begin
        acc_n   = 0;
        pready  = 1'($urandom);
        prdata  = $urandom;
        pslverr = 1'($urandom);
      end
    end
  end

  // Monitor: bus stability, scoreboard pop, response hold checks.
  initial begin
    exp_t          cur;
    bit            in_rsp;
    bit            prev_hs;
    int            hcnt;
    int            acc_seen;
    logic [DW-1:0] h_rdata;
    logic          h_err;
    in_rsp   = 0;
    prev_hs  = 0;
    hcnt     = 0;
    acc_seen = 0;
    h_rdata  = '0;
    h_err    = 1'b0;
    cur      = '{rdata: '0, err: 1'b0, lat: 0, acc: 0, hold: 0};
    forever begin
      @(negedge pclk);
      if (penable) check("penable_psel", 32'(psel), 32'd1);
      if (psel) begin
        check("paddr", 32'(paddr), 32'(a_addr));
        check("pwrite", 32'(pwrite), 32'(a_wr));
        check("pwdata", pwdata, a_wdata);
        if (!penable) acc_seen = 0;
        else acc_seen++;
      end
      if (prev_hs) check("rsp_drop", 32'(rsp_valid), 32'd0);
      prev_hs = 0;
      if (rsp_valid) begin
        check("psel_resp", 32'(psel), 32'd0);
        check("cmd_ready_resp", 32'(cmd_ready), 32'd0);
        if (!in_rsp) begin
          check("outstanding", 32'(exp_q.size()), 32'd1);
          if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            check("rsp_rdata", rsp_rdata, cur.rdata);
            check("rsp_err", 32'(rsp_err), 32'(cur.err));
            check("latency", 32'(cyc), 32'(cur.lat));
            check("access_cycles", 32'(acc_seen), 32'(cur.acc));
          end
          in_rsp  = 1;
          h_rdata = rsp_rdata;
          h_err   = rsp_err;
          hcnt    = 0;
        end else begin
          check("hold_rdata", rsp_rdata, h_rdata);
          check("hold_err", 32'(rsp_err), 32'(h_err));
        end
        if (hcnt >= cur.hold && $urandom_range(0, 3) != 0) begin
          rsp_ready = 1'b1;
          prev_hs   = 1;
        end else begin
          rsp_ready = 1'b0;
        end
        hcnt++;
      end else begin
        in_rsp    = 0;
        rsp_ready = 1'($urandom);
      end
    end
  end

  // Main sequence: reset, directed cases, random traffic, drain.
  initial begin
    int w;
    repeat (2) @(posedge pclk);
    #1;
    check("rst_psel", 32'(psel), 32'd0);
    check("rst_penable", 32'(penable), 32'd0);
    check("rst_paddr", 32'(paddr), 32'd0);
    check("rst_pwdata", pwdata, 32'd0);
    check("rst_pwrite", 32'(pwrite), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    @(negedge pclk);
    presetn = 1'b1;
    #1;
    check("rel_cmd_ready0", 32'(cmd_ready), 32'd0);
    @(negedge pclk);
    check("rel_cmd_ready1", 32'(cmd_ready), 32'd1);

    issue(5'h04, 1'b1, 32'hDEADBEEF, 0, 1'b0, 32'h0BADF00D, 0);
    issue(5'h0C, 1'b0, 32'h0, 0, 1'b0, 32'h12345678, 0);
    issue(5'h0C, 1'b0, 32'h0, 3, 1'b1, 32'hA5A5A5A5, 0);
    issue(5'h15, 1'b0, 32'h0, 40, 1'b0, 32'h11111111, 0);
    issue(5'h16, 1'b0, 32'h0, TO - 1, 1'b0, 32'hCAFE0001, 0);
    issue(5'h17, 1'b1, 32'h55AA55AA, TO, 1'b0, 32'h0, 0);
    issue(5'h08, 1'b0, 32'h0, 1, 1'b0, 32'h87654321, 5);

    issue(5'h11, 1'b0, 32'h0, 10, 1'b0, 32'h22222222, 0);
    repeat (4) @(negedge pclk);
    check("pre_rst_access", 32'(psel & penable), 32'd1);
    #2;
    presetn = 1'b0;
    #1;
    check("arst_psel", 32'(psel), 32'd0);
    check("arst_penable", 32'(penable), 32'd0);
    check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("arst_cmd_ready", 32'(cmd_ready), 32'd0);
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    repeat (2) @(negedge pclk);
    presetn = 1'b1;
    @(negedge pclk);
    check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    issue(5'h1F, 1'b0, 32'h0, 0, 1'b0, 32'h33333333, 0);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) < 7) w = $urandom_range(0, 4);
      else w = $urandom_range(TO - 2, TO + 2);
      issue(AW'($urandom), 1'($urandom), $urandom, w,
            1'($urandom_range(0, 3) == 0), $urandom,
            $urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0)
        repeat ($urandom_range(1, 3)) @(negedge pclk);
    end

    for (int k = 0; k < 500; k++) begin
      if (exp_q.size() == 0 && !rsp_valid) break;
      @(negedge pclk);
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL provide parameter DW, default 32, APB and command data width.
REQ-002 SHALL provide parameter AW, default 5, APB and command address width.
REQ-003 SHALL provide parameter TIMEOUT, default 16, the maximum number of ACCESS cycles waited for pready (minimum 1).
REQ-004 SHALL have one clock and an asynchronous, active-low reset: pclk  in  1  clock; presetn  in  1  asynchronous active-low reset.
REQ-005 SHALL have cmd_valid  in  1  command request.
REQ-006 SHALL have cmd_ready  out  1  command accepted when high with cmd_valid.
REQ-007 SHALL have cmd_addr  in  AW  target address.
REQ-008 SHALL have cmd_write  in  1  1=write, 0=read.
REQ-009 SHALL have cmd_wdata  in  DW  write data.
REQ-010 SHALL have rsp_valid  out  1  response available.
REQ-011 SHALL have rsp_ready  in  1  response consumed when high with rsp_valid.
REQ-012 SHALL have rsp_rdata  out  DW  read data.
REQ-013 SHALL have rsp_err  out  1  slave error or timeout.
REQ-014 SHALL have APB requester ports: paddr out AW; psel out 1; penable out 1; pwrite out 1; pwdata out DW; pready in 1; prdata in DW; pslverr in 1.

Function
REQ-015 SHALL implement the states IDLE, SETUP, ACCESS and RESP; all outputs SHALL be driven from registers.
REQ-016 SHALL drive cmd_ready=1 only in IDLE; cmd_valid&cmd_ready at edge T SHALL latch addr/write/wdata onto paddr/pwrite/pwdata and enter SETUP.
REQ-017 SETUP SHALL drive psel=1 and penable=0 for exactly one cycle, then enter ACCESS.
REQ-018 ACCESS SHALL drive psel=1 and penable=1, with paddr/pwrite/pwdata held stable from SETUP until exit.
REQ-019 SHALL sample pready, prdata and pslverr only in ACCESS; pready=1 SHALL capture rsp_err=pslverr, capture rsp_rdata=prdata for reads or 0 for writes, clear psel/penable, and enter RESP.
REQ-020 Minimum latency SHALL be: accept at edge T, SETUP in cycle T+1, ACCESS in cycle T+2, rsp_valid=1 from T+3 when pready=1 in the first ACCESS cycle.
REQ-021 SHALL keep a wait counter that is cleared on entering ACCESS and incremented on each ACCESS cycle with pready=0; when the count reaches TIMEOUT-1 with pready=0, the block SHALL abort: psel/penable=0, rsp_err=1, rsp_rdata=0, enter RESP.
REQ-022 pready=1 in the same cycle the timeout would fire SHALL complete normally (no timeout error).
REQ-023 RESP SHALL hold rsp_valid, rsp_rdata and rsp_err stable until rsp_ready=1, then return to IDLE with rsp_valid=0; the earliest next accept SHALL be the following cycle (back-to-back commands separated by at least one IDLE cycle).
REQ-024 pready, prdata and pslverr outside ACCESS SHALL be ignored; cmd_* inputs outside IDLE SHALL be ignored.
REQ-025 psel SHALL never be high with state IDLE or RESP; penable SHALL never be high without psel.

Reset
REQ-026 presetn=0 SHALL immediately force state=IDLE, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0; cmd_ready SHALL be 0 during reset and 1 from the first clock edge after release.
REQ-027 Reset asserted mid-transfer SHALL abandon the transfer with no response issued.

Verification
REQ-028 Write addr 0x04 data 0xDEADBEEF, pready=1 -> SETUP then one ACCESS cycle with pwrite=1; rsp_valid at T+3 with rsp_err=0, rsp_rdata=0.
REQ-029 Read addr 0x0C, slave returns prdata=0x12345678 with pready=1 -> rsp_rdata=0x12345678, rsp_err=0.
REQ-030 Read with pready low for 3 ACCESS cycles then high with pslverr=1 -> ACCESS lasts 4 cycles, address stable throughout, rsp_err=1.
REQ-031 pready held low, TIMEOUT=16 -> abort after 16 ACCESS cycles; rsp_err=1, rsp_rdata=0, psel=0.
REQ-032 rsp_ready held low for 5 cycles -> rsp_valid and data stable, cmd_ready=0, no new APB transfer.
REQ-033 presetn pulsed low during ACCESS -> psel/penable drop asynchronously, no rsp_valid, and the next command completes normally.
